squash_game_ctrl: RTL and testbench
===================================

SQUASH_GAME_CTRL -- requirements
Module: squash_game_ctrl

Interface
REQ-001 SHALL have parameter LIVES, default 3, meaning balls per game (1..3).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, meaning frames the core is held paused before each serve.
REQ-003 SHALL have parameter MISS_FRAMES, default 90, meaning frames of freeze after a miss.
REQ-004 SHALL have parameter DEBOUNCE_FRAMES, default 4, meaning consecutive low frame samples needed for a button press.
REQ-005 SHALL have port clk, input, 1, 25MHz pixel clock.
REQ-006 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port frame_tick, input, 1, one-cycle pulse per frame, coincident with core hmax&vmax.
REQ-008 SHALL have port start_n, input, 1, raw asynchronous start button, active-low.
REQ-009 SHALL have port pause_btn_n, input, 1, raw asynchronous pause button, active-low.
REQ-010 SHALL have port hit, input, 1, core paddle-hit level.
REQ-011 SHALL have port miss, input, 1, one-cycle pulse when the ball passes the paddle column.
REQ-012 SHALL have port core_pause_n, output, 1, drives core pause_n.
REQ-013 SHALL have port core_new_game_n, output, 1, drives core new_game_n.
REQ-014 SHALL have port score, output, 8, two BCD digits, [7:4] tens.
REQ-015 SHALL have port lives, output, 2, remaining balls.
REQ-016 SHALL have port state, output, 3, current FSM state encoding.
REQ-017 SHALL have port game_over, output, 1, high while in OVER.

Function
REQ-018 SHALL synchronise each button through two flops, then sample it only on frame_tick.
REQ-019 SHALL emit one single-cycle press event after DEBOUNCE_FRAMES consecutive low samples; a further event SHALL require at least one high sample first.
REQ-020 SHALL detect rising edges of hit with a registered copy; only the edge counts.
REQ-021 SHALL implement states ATTRACT=0, SERVE=1, PLAY=2, PAUSED=3, MISS=4, OVER=5.
REQ-022 ATTRACT: core_pause_n=0; start press -> SERVE, score<=0, lives<=LIVES.
REQ-023 SERVE: core_pause_n=0; core_new_game_n SHALL be 0 for exactly the first cycle in SERVE; after SERVE_FRAMES frame_ticks -> PLAY.
REQ-024 PLAY: core_pause_n=1; hit edge -> BCD score+1, saturating at 0x99; miss -> MISS with lives-1; pause press -> PAUSED.
REQ-025 PAUSED: core_pause_n=0; pause press -> PLAY; score, lives and frame counter SHALL be held.
REQ-026 MISS: core_pause_n=0; after MISS_FRAMES frame_ticks -> OVER if lives==0, else SERVE.
REQ-027 OVER: game_over=1, core_pause_n=0; start press -> SERVE with score<=0, lives<=LIVES.
REQ-028 SHALL clear the frame counter on every state entry and advance it only on frame_tick.
REQ-029 SHALL give miss priority over hit and over pause press in the same PLAY cycle; score is not incremented.
REQ-030 SHALL ignore hit, miss and pause press outside PLAY (pause also in PAUSED); start press SHALL be ignored outside ATTRACT and OVER.
REQ-031 SHALL reach the state transition in the cycle after the qualifying event (1-cycle latency); all outputs SHALL be registered.

Reset
REQ-032 On reset_n low, asynchronously: state=ATTRACT, score=0x00, lives=LIVES, core_pause_n=0, core_new_game_n=1, game_over=0, counters and debouncers cleared (buttons treated as released).
REQ-033 Reset mid-game SHALL abandon the game with no residual press or hit events after release.

Structure
REQ-034 squash_pkg SHALL hold the state encodings, BCD_W=8 and LIVES_W=2.
REQ-035 Debounce SHALL be sub-module squash_debounce, instanced twice.

Verification (LIVES=2, SERVE_FRAMES=2, MISS_FRAMES=3, DEBOUNCE_FRAMES=2)
REQ-036 start_n low for 2 ticks in ATTRACT -> SERVE, core_new_game_n low 1 cycle, lives=2; 2 ticks later state=PLAY and core_pause_n=1.
REQ-037 PLAY, hit pulsed 12 times -> score=0x12; from score 0x99, one more hit -> score stays 0x99.
REQ-038 PLAY, hit and miss in the same cycle -> MISS, score unchanged, lives=1; 3 ticks later -> SERVE.
REQ-039 Second miss -> lives=0; after 3 ticks -> OVER, game_over=1; a start press -> SERVE with score=0x00, lives=2.
REQ-040 Pause held low for 10 ticks -> exactly one PAUSED entry; release then press again -> PLAY; reset_n low mid-PLAY -> ATTRACT immediately, all outputs at reset values.

Source files
------------

// File: rtl/squash_pkg.sv
// Shared encodings and helpers for the squash game controller.
package squash_pkg;

    localparam int BCD_W   = 8;
    localparam int LIVES_W = 2;

    typedef enum logic [2:0] {
        ATTRACT = 3'd0,
        SERVE   = 3'd1,
        PLAY    = 3'd2,
        PAUSED  = 3'd3,
        MISS    = 3'd4,
        OVER    = 3'd5
    } state_t;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [BCD_W-1:0] bcd_inc_sat(input logic [BCD_W-1:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = v[3:0];
        hi = v[7:4];
        if (v == 8'h99) begin
            return v;
        end
        if (lo == 4'd9) begin
            lo = 4'd0;
            hi = hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

endpackage

// File: rtl/squash_debounce.sv
// Button conditioner: two-flop synchroniser, frame-rate sampling, and a
// single press pulse once the button has been seen low for FRAMES samples.
module squash_debounce #(
    parameter int FRAMES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_tick,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = $clog2(FRAMES + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAMES);

    logic [1:0]       sync;
    logic [CNT_W-1:0] low_cnt;

    // Synchroniser resets to "released" so reset never manufactures a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], btn_n};
        end
    end

    // Count low samples; the counter parks at FULL until a high sample rearms it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            low_cnt <= '0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (frame_tick) begin
                if (sync[1]) begin
                    low_cnt <= '0;
                end else if (low_cnt != FULL) begin
                    low_cnt <= low_cnt + 1'b1;
                    if (low_cnt == FULL - 1'b1) begin
                        press <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/squash_game_ctrl.sv
// Game sequencing around the squash core: attract, serve delay, play,
// pause, miss freeze and game over, with BCD scoring and ball count.
//
// state   | meaning
// --------+-------------------------------------------------
// ATTRACT | idle after reset, waiting for start
// SERVE   | core held paused for SERVE_FRAMES before the ball
// PLAY    | core running, hits score, miss loses a ball
// PAUSED  | user pause, everything frozen
// MISS    | freeze for MISS_FRAMES after a lost ball
// OVER    | no balls left, waiting for start
module squash_game_ctrl
    import squash_pkg::*;
#(
    parameter int LIVES           = 3,
    parameter int SERVE_FRAMES    = 60,
    parameter int MISS_FRAMES     = 90,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               start_n,
    input  logic               pause_btn_n,
    input  logic               hit,
    input  logic               miss,
    output logic               core_pause_n,
    output logic               core_new_game_n,
    output logic [BCD_W-1:0]   score,
    output logic [LIVES_W-1:0] lives,
    output logic [2:0]         state,
    output logic               game_over
);

    localparam int FMAX   = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int FCNT_W = $clog2(FMAX + 1);
    localparam logic [FCNT_W-1:0]  SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
    localparam logic [FCNT_W-1:0]  MISS_LAST  = FCNT_W'(MISS_FRAMES - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    state_t            state_q;
    state_t            state_next;
    logic [FCNT_W-1:0] frame_cnt;
    logic              hit_q;
    logic              hit_edge;
    logic              start_press;
    logic              pause_press;
    logic              pause_n_d;
    logic              new_game_n_d;
    logic              game_over_d;

    squash_debounce #(.FRAMES(DEBOUNCE_FRAMES)) u_start_db (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .btn_n      (start_n),
        .press      (start_press)
    );

    squash_debounce #(.FRAMES(DEBOUNCE_FRAMES)) u_pause_db (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .btn_n      (pause_btn_n),
        .press      (pause_press)
    );

    assign hit_edge = hit & ~hit_q;
    assign state    = state_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ATTRACT;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state decode; miss outranks pause within PLAY.
    always_comb begin
        state_next = state_q;
        case (state_q)
            ATTRACT: if (start_press) state_next = SERVE;
            SERVE:   if (frame_tick && frame_cnt == SERVE_LAST) state_next = PLAY;
            PLAY: begin
                if (miss) begin
                    state_next = MISS;
                end else if (pause_press) begin
                    state_next = PAUSED;
                end
            end
            PAUSED:  if (pause_press) state_next = PLAY;
            MISS: begin
                if (frame_tick && frame_cnt == MISS_LAST) begin
                    state_next = (lives == '0) ? OVER : SERVE;
                end
            end
            OVER:    if (start_press) state_next = SERVE;
            default: state_next = ATTRACT;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        pause_n_d    = (state_next == PLAY);
        new_game_n_d = !((state_next == SERVE) && (state_q != SERVE));
        game_over_d  = (state_next == OVER);
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_pause_n    <= 1'b0;
            core_new_game_n <= 1'b1;
            game_over       <= 1'b0;
        end else begin
            core_pause_n    <= pause_n_d;
            core_new_game_n <= new_game_n_d;
            game_over       <= game_over_d;
        end
    end

    // Frame timer, hit edge history, score and ball count.
    // hit_q resets high so a hit level held through reset is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            hit_q     <= 1'b1;
            score     <= '0;
            lives     <= LIVES_INIT;
        end else begin
            hit_q <= hit;
            if (state_next != state_q) begin
                frame_cnt <= '0;
            end else if (frame_tick && (state_q == SERVE || state_q == MISS)) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            case (state_q)
                ATTRACT, OVER: begin
                    if (start_press) begin
                        score <= '0;
                        lives <= LIVES_INIT;
                    end
                end
                PLAY: begin
                    if (miss) begin
                        lives <= lives - 1'b1;
                    end else if (hit_edge) begin
                        score <= bcd_inc_sat(score);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_squash_game_ctrl.sv
// Directed vector bench for squash_game_ctrl with small timing parameters.
module tb_squash_game_ctrl;

    typedef enum int {OP_START, OP_PAUSE, OP_TICKS, OP_HITS, OP_MISS, OP_HIT_MISS} op_t;

    typedef struct {
        op_t        op;
        int         n;
        logic [2:0] st;
        logic [7:0] sc;
        logic [1:0] lv;
        logic       pn;
        logic       go;
        int         ng;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start_n = 1'b1;
    logic       pause_btn_n = 1'b1;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       core_pause_n;
    logic       core_new_game_n;
    logic [7:0] score;
    logic [1:0] lives;
    logic [2:0] state;
    logic       game_over;

    int n_vec = 0;
    int n_bad = 0;
    int ng_cnt = 0;
    int paused_entries = 0;
    logic [2:0] prev_st = 3'd0;

    vec_t vecs[$];

    squash_game_ctrl #(
        .LIVES(2), .SERVE_FRAMES(2), .MISS_FRAMES(3), .DEBOUNCE_FRAMES(2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .frame_tick      (frame_tick),
        .start_n         (start_n),
        .pause_btn_n     (pause_btn_n),
        .hit             (hit),
        .miss            (miss),
        .core_pause_n    (core_pause_n),
        .core_new_game_n (core_new_game_n),
        .score           (score),
        .lives           (lives),
        .state           (state),
        .game_over       (game_over)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!core_new_game_n) ng_cnt++;
        if (state == 3'd3 && prev_st != 3'd3) paused_entries++;
        prev_st = state;
    end

    function automatic vec_t mk(op_t op, int n, logic [2:0] st, logic [7:0] sc,
                                logic [1:0] lv, logic pn, logic go, int ng);
        vec_t v;
        v.op = op; v.n = n; v.st = st; v.sc = sc; v.lv = lv; v.pn = pn; v.go = go; v.ng = ng;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        repeat (3) step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (4) step();
    endtask

    task automatic apply(input vec_t v);
        case (v.op)
            OP_START: begin
                start_n = 1'b0;
                repeat (2) tick();
                start_n = 1'b1;
                repeat (2) step();
            end
            OP_PAUSE: begin
                pause_btn_n = 1'b0;
                repeat (v.n) tick();
                pause_btn_n = 1'b1;
                tick();
            end
            OP_TICKS: repeat (v.n) tick();
            OP_HITS: repeat (v.n) begin
                hit = 1'b1; step();
                hit = 1'b0; step();
            end
            OP_MISS: begin
                miss = 1'b1; step();
                miss = 1'b0; repeat (2) step();
            end
            OP_HIT_MISS: begin
                hit = 1'b1; miss = 1'b1; step();
                hit = 1'b0; miss = 1'b0; repeat (2) step();
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] st, input logic [7:0] sc,
                                 input logic [1:0] lv, input logic pn, input logic go);
        check({tag, " state"}, int'(state), int'(st));
        check({tag, " score"}, int'(score), int'(sc));
        check({tag, " lives"}, int'(lives), int'(lv));
        check({tag, " core_pause_n"}, int'(core_pause_n), int'(pn));
        check({tag, " game_over"}, int'(game_over), int'(go));
    endtask

    initial begin
        int pe0;

        vecs.push_back(mk(OP_PAUSE,    2, 3'd0, 8'h00, 2'd2, 1'b0, 1'b0, 0));
        vecs.push_back(mk(OP_START,    0, 3'd1, 8'h00, 2'd2, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_TICKS,    1, 3'd1, 8'h00, 2'd2, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_TICKS,    1, 3'd2, 8'h00, 2'd2, 1'b1, 1'b0, 1));
        vecs.push_back(mk(OP_HITS,    12, 3'd2, 8'h12, 2'd2, 1'b1, 1'b0, 1));
        vecs.push_back(mk(OP_HIT_MISS, 0, 3'd4, 8'h12, 2'd1, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_TICKS,    2, 3'd4, 8'h12, 2'd1, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_TICKS,    1, 3'd1, 8'h12, 2'd1, 1'b0, 1'b0, 2));
        vecs.push_back(mk(OP_TICKS,    2, 3'd2, 8'h12, 2'd1, 1'b1, 1'b0, 2));
        vecs.push_back(mk(OP_PAUSE,    2, 3'd3, 8'h12, 2'd1, 1'b0, 1'b0, 2));
        vecs.push_back(mk(OP_HITS,     1, 3'd3, 8'h12, 2'd1, 1'b0, 1'b0, 2));
        vecs.push_back(mk(OP_MISS,     0, 3'd3, 8'h12, 2'd1, 1'b0, 1'b0, 2));
        vecs.push_back(mk(OP_PAUSE,    2, 3'd2, 8'h12, 2'd1, 1'b1, 1'b0, 2));
        vecs.push_back(mk(OP_HITS,    87, 3'd2, 8'h99, 2'd1, 1'b1, 1'b0, 2));
        vecs.push_back(mk(OP_HITS,     1, 3'd2, 8'h99, 2'd1, 1'b1, 1'b0, 2));
        vecs.push_back(mk(OP_MISS,     0, 3'd4, 8'h99, 2'd0, 1'b0, 1'b0, 2));
        vecs.push_back(mk(OP_TICKS,    3, 3'd5, 8'h99, 2'd0, 1'b0, 1'b1, 2));
        vecs.push_back(mk(OP_HITS,     1, 3'd5, 8'h99, 2'd0, 1'b0, 1'b1, 2));
        vecs.push_back(mk(OP_MISS,     0, 3'd5, 8'h99, 2'd0, 1'b0, 1'b1, 2));
        vecs.push_back(mk(OP_START,    0, 3'd1, 8'h00, 2'd2, 1'b0, 1'b0, 3));
        vecs.push_back(mk(OP_TICKS,    2, 3'd2, 8'h00, 2'd2, 1'b1, 1'b0, 3));

        repeat (3) step();
        check("reset core_new_game_n", int'(core_new_game_n), 1);
        check_outputs("reset", 3'd0, 8'h00, 2'd2, 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check_outputs($sformatf("v%0d", i), vecs[i].st, vecs[i].sc, vecs[i].lv,
                          vecs[i].pn, vecs[i].go);
            check($sformatf("v%0d new_game pulses", i), ng_cnt, vecs[i].ng);
        end

        // Pause held for many frames gives exactly one pause entry.
        pe0 = paused_entries;
        pause_btn_n = 1'b0;
        repeat (10) tick();
        check("held pause entries", paused_entries - pe0, 1);
        check("held pause state", int'(state), 3);
        pause_btn_n = 1'b1;
        tick();
        pause_btn_n = 1'b0;
        repeat (2) tick();
        pause_btn_n = 1'b1;
        tick();
        check("resume state", int'(state), 2);
        check("resume core_pause_n", int'(core_pause_n), 1);

        // Reset mid-play with hit held high across release.
        hit = 1'b1;
        step();
        reset_n = 1'b0;
        #2;
        check("async reset core_new_game_n", int'(core_new_game_n), 1);
        check_outputs("async reset", 3'd0, 8'h00, 2'd2, 1'b0, 1'b0);
        step();
        reset_n = 1'b1;
        repeat (4) step();
        hit = 1'b0;
        repeat (2) step();
        check_outputs("post reset", 3'd0, 8'h00, 2'd2, 1'b0, 1'b0);
        check("post reset new_game pulses", ng_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
